// File: rtl/nibble_serial_subtractor_16_pkg.sv
// ============================================================================
// nibble_sub_pkg : shared constants and FSM state type for the serial subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

package nibble_sub_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int NIBBLE_DEF      = 4;
  localparam int NUM_NIBBLES_DEF = WIDTH_DEF / NIBBLE_DEF;
  localparam int CNT_W           = $clog2(NUM_NIBBLES_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_subtractor_16_if.sv
// ============================================================================
// nibble_sub_if : request/result valid-ready bundle of the serial subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

interface nibble_sub_if
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_subtractor_16_subtractor_4.sv
// ============================================================================
// subtractor_4 : combinational 4-bit ripple-borrow subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module subtractor_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);
  logic [4:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bout = borrow[4];
endmodule

`default_nettype wire

// File: rtl/nibble_serial_subtractor_16.sv
// ============================================================================
// nibble_serial_subtractor_16 : a - b - bin, one nibble per cycle, valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_serial_subtractor_16
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NIBBLE = NIBBLE_DEF
) (
  input logic         clk,
  input logic         rst_n,
  nibble_sub_if.slave bus
);
  localparam int NUM_NIBBLES = WIDTH / NIBBLE;
  localparam int CW          = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [NUM_NIBBLES-1:0][NIBBLE-1:0] a_q;
  logic [NUM_NIBBLES-1:0][NIBBLE-1:0] b_q;
  logic [NUM_NIBBLES-1:0][NIBBLE-1:0] diff_q;
  logic [NUM_NIBBLES-1:0][NIBBLE-1:0] diff_next;
  logic                               borrow;
  logic                               bout_q;
  logic                               ovf_q;
  logic                               zero_q;
  logic                               in_ready_q;
  logic                               out_valid_q;
  logic [NIBBLE-1:0]                  nib_diff;
  logic                               nib_bout;

  // Single shared nibble slice, steered by the counter.
  subtractor_4 u_sub (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .bin  (borrow),
    .diff (nib_diff),
    .bout (nib_bout)
  );

  always_comb begin
    diff_next      = diff_q;
    diff_next[cnt] = nib_diff;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      borrow      <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            borrow     <= bus.bin;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          diff_q <= diff_next;
          borrow <= nib_bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout_q      <= nib_bout;
            ovf_q       <= (a_q[NUM_NIBBLES-1][NIBBLE-1] != b_q[NUM_NIBBLES-1][NIBBLE-1]) &&
                           (diff_next[NUM_NIBBLES-1][NIBBLE-1] != a_q[NUM_NIBBLES-1][NIBBLE-1]);
            zero_q      <= (diff_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor_16.sv
// Self-checking bench: directed cases plus random operands against an arithmetic model.
`default_nettype none

module tb_nibble_serial_subtractor_16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  nibble_sub_if #(.WIDTH(16)) bus ();

  nibble_serial_subtractor_16 #(.WIDTH(16), .NIBBLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                output logic [15:0] d, output logic bo, output logic ov,
                                output logic z);
    int ua, ub, ib, r, sr;
    ua = int'(a);
    ub = int'(b);
    ib = int'(bin);
    r  = ua - ub - ib;
    d  = 16'(r);
    bo = (ua < ub + ib);
    sr = int'($signed(a)) - int'($signed(b)) - ib;
    ov = (sr < -32768) || (sr > 32767);
    z  = (d == 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [15:0] d;
    logic bo, ov, z;
    int lat;
    model(a, b, bin, d, bo, ov, z);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("diff", 32'(bus.diff), 32'(d));
    chk("bout", 32'(bus.bout), 32'(bo));
    chk("ovf", 32'(bus.ovf), 32'(ov));
    chk("zero", 32'(bus.zero), 32'(z));
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drop_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    start_op(a, b, bin);
    wait_result(a, b, bin);
    release_result();
  endtask

  initial begin
    logic [15:0] ra, rb, held;
    logic rbin;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'h5555, 16'h5554, 1'b1);

    // Backpressure with a competing request held during DONE
    start_op(16'h00F0, 16'h000F, 1'b0);
    wait_result(16'h00F0, 16'h000F, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 16'h4000;
    bus.b        = 16'h1001;
    bus.bin      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_diff", 32'(bus.diff), 32'h00E1);
      chk("bp_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_drop_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready_idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_accepted", 32'(bus.in_ready), 32'd0);
    wait_result(16'h4000, 16'h1001, 1'b1);
    release_result();

    // Reset during the second BUSY cycle
    start_op(16'h1234, 16'h1111, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_diff", 32'(bus.diff), 32'd0);
    chk("midrst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_release_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_result", 32'(bus.out_valid), 32'd0);
    end
    run_op(16'h0003, 16'h0001, 1'b0);

    // Random operands with random consumer stall
    for (int n = 0; n < 24; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (n % 6 == 0) rb = ra;
      start_op(ra, rb, rbin);
      wait_result(ra, rb, rbin);
      held = bus.diff;
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        tick();
        chk("rnd_hold", 32'(bus.diff), 32'(held));
      end
      release_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
